// File: rtl/buffer_serializer_if.sv
// -----------------------------------------------------------------------------
// buffer_serializer_if
//   Bundles the buffer-head side and the serial-lane side of the
//   buffer_serializer into one interface.
//
//   Buffer side : buf_data (head word), buf_empty, buf_pop (1-cycle pop strobe)
//   Lane side   : ser_data, ser_valid, ser_ready, ser_sop, ser_eop, link_id
//   Optional    : ser_par (present only when BUFFER_SERIALIZER_PARITY_EN is
//                 defined)
//
//   modport master : the serializer itself
//   modport slave  : the environment (buffer + link driver)
// -----------------------------------------------------------------------------
interface buffer_serializer_if #(
  parameter int DATA_WIDTH = 40,
  parameter int LANE_WIDTH = 8,
  parameter int LINK_BITS  = 2
);
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_empty;
  logic                  buf_pop;
  logic [LANE_WIDTH-1:0] ser_data;
  logic                  ser_valid;
  logic                  ser_ready;
  logic                  ser_sop;
  logic                  ser_eop;
  logic [LINK_BITS-1:0]  link_id;
`ifdef BUFFER_SERIALIZER_PARITY_EN
  logic                  ser_par;

  modport master (
    input  buf_data, buf_empty, ser_ready,
    output buf_pop, ser_data, ser_valid, ser_sop, ser_eop, link_id, ser_par
  );
  modport slave (
    output buf_data, buf_empty, ser_ready,
    input  buf_pop, ser_data, ser_valid, ser_sop, ser_eop, link_id, ser_par
  );
`else
  modport master (
    input  buf_data, buf_empty, ser_ready,
    output buf_pop, ser_data, ser_valid, ser_sop, ser_eop, link_id
  );
  modport slave (
    output buf_data, buf_empty, ser_ready,
    input  buf_pop, ser_data, ser_valid, ser_sop, ser_eop, link_id
  );
`endif
endinterface

// File: rtl/buffer_serializer.sv
// -----------------------------------------------------------------------------
// buffer_serializer
//   Drains one DATA_WIDTH word at a time from the link buffer head and sends
//   it MSB-first as DATA_WIDTH/LANE_WIDTH beats on a valid/ready lane. The
//   header link number is presented on link_id for every beat of the word,
//   and sop/eop mark the first and last beat. When the next word is already
//   waiting, it is popped on the last-beat edge so words go back-to-back.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-low reset
//     bus  : buffer_serializer_if.master (buffer head + serial lane)
//
//   Optional feature (macro BUFFER_SERIALIZER_PARITY_EN):
//     adds bus.ser_par = even parity (XOR) of the current beat.
//
//   DATA_WIDTH must be an integer multiple of LANE_WIDTH.
// -----------------------------------------------------------------------------
module buffer_serializer #(
  parameter int DATA_WIDTH = 40,
  parameter int LANE_WIDTH = 8,
  parameter int LINK_BITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_serializer_if.master    bus
);

  localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [LINK_BITS-1:0]  link_q,  link_d;

  logic                  valid;
  logic                  xfer;
  logic                  last_beat;
  logic                  pop;
  logic [LANE_WIDTH-1:0] beat;

  // Next-state / output logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    link_d  = link_q;

    valid     = (state_q == SEND);
    xfer      = valid && bus.ser_ready;
    last_beat = (count_q == LAST_CNT);
    // rst is folded in so no pop can leak out while reset is held: the
    // buffer would otherwise lose a word we never capture.
    pop       = rst && !bus.buf_empty &&
                ((state_q == IDLE) || (xfer && last_beat));

    if (pop) begin
      // Covers both the IDLE start and the no-bubble reload on the last beat.
      shift_d = bus.buf_data;
      link_d  = bus.buf_data[DATA_WIDTH-1 -: LINK_BITS];
      count_d = '0;
      state_d = SEND;
    end else if (xfer) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        shift_d = shift_q << LANE_WIDTH;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      link_q  <= link_d;
    end
  end

  assign beat          = shift_q[DATA_WIDTH-1 -: LANE_WIDTH];
  assign bus.buf_pop   = pop;
  assign bus.ser_data  = beat;
  assign bus.ser_valid = valid;
  assign bus.ser_sop   = valid && (count_q == '0);
  assign bus.ser_eop   = valid && last_beat;
  assign bus.link_id   = link_q;

`ifdef BUFFER_SERIALIZER_PARITY_EN
  // Follows the shift register, so it holds through stalls and is 0 in reset.
  assign bus.ser_par   = ^beat;
`endif

endmodule

// File: tb/tb_buffer_serializer.sv
// -----------------------------------------------------------------------------
// tb_buffer_serializer
//   Directed bench for buffer_serializer. Words placed in the modelled buffer
//   queue also push their expected beats into a scoreboard; every accepted
//   beat is popped from the scoreboard and compared.
// -----------------------------------------------------------------------------
module tb_buffer_serializer;

  localparam int DW    = 40;
  localparam int LW    = 8;
  localparam int LB    = 2;
  localparam int BEATS = DW / LW;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          sop;
    logic          eop;
    logic [LB-1:0] link;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  buffer_serializer_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .LINK_BITS(LB)) bus ();

  buffer_serializer #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .LINK_BITS(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  beat_t         sb[$];
  logic [DW-1:0] bq[$];

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int run = 0;
  int maxrun = 0;
  int sop_cyc = -1;
  int eop_cyc = -1;
  int pop_cyc = -1;
  int npops = 0;
  int eop_pops = 0;
  logic [7:0] par_hist = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    beat_t b;
    bq.push_back(w);
    for (int i = 0; i < BEATS; i++) begin
      b.data = w[DW-1-i*LW -: LW];
      b.sop  = (i == 0);
      b.eop  = (i == BEATS - 1);
      b.link = w[DW-1 -: LB];
      sb.push_back(b);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 ns later.
  task automatic tick(input logic rdy);
    beat_t e;
    @(negedge clk);
    bus.ser_ready = rdy;
    bus.buf_empty = (bq.size() == 0);
    bus.buf_data  = (bq.size() != 0) ? bq[0] : '0;
    #1;
    cyc++;
    if (bus.ser_valid) begin
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (bus.ser_valid && bus.ser_ready) begin
      chk("beat_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("cyc %0d beat data=%02h sop=%0b eop=%0b link=%0d", cyc,
                 bus.ser_data, bus.ser_sop, bus.ser_eop, bus.link_id);
        chk("beat_data", bus.ser_data, e.data);
        chk("beat_sop",  bus.ser_sop,  e.sop);
        chk("beat_eop",  bus.ser_eop,  e.eop);
        chk("beat_link", bus.link_id,  e.link);
`ifdef BUFFER_SERIALIZER_PARITY_EN
        par_hist = {par_hist[6:0], bus.ser_par};
`endif
      end
      if (bus.ser_sop) sop_cyc = cyc;
      if (bus.ser_eop) eop_cyc = cyc;
    end
    if (bus.buf_pop) begin
      $display("cyc %0d pop", cyc);
      npops++;
      pop_cyc = cyc;
      if (bus.ser_eop) eop_pops++;
      chk("pop_has_word", (bq.size() > 0), 1);
      if (bq.size() > 0) void'(bq.pop_front());
    end
  endtask

  initial begin
    // ---------------- reset held, word waiting: no pop allowed
    bus.ser_ready = 1'b1;
    bus.buf_empty = 1'b0;
    bus.buf_data  = 40'hA1_2233_4455;
    #1;
    chk("rst_pop_gated", bus.buf_pop, 0);
    tick(1);
    tick(1);
    chk("rst_valid", bus.ser_valid, 0);
    chk("rst_sop",   bus.ser_sop,   0);
    chk("rst_eop",   bus.ser_eop,   0);
    chk("rst_data",  bus.ser_data,  0);
    chk("rst_link",  bus.link_id,   0);
    chk("rst_pop",   bus.buf_pop,   0);
    rst = 1'b1;
    tick(1);
    tick(1);
    chk("idle_valid", bus.ser_valid, 0);

    // ---------------- T1: single word, latency and framing
    npops = 0;
    push_word(40'hA1_2233_4455);
    repeat (7) tick(1);
    chk("t1_pops",     npops,   1);
    chk("t1_sop_cyc",  sop_cyc, pop_cyc + 1);
    chk("t1_eop_cyc",  eop_cyc, pop_cyc + 5);
    chk("t1_idle",     bus.ser_valid, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // ---------------- T2: back-to-back words
    maxrun = 0; eop_pops = 0; npops = 0;
    push_word(40'h00_0000_0001);
    push_word(40'hFF_FFFF_FFFE);
    repeat (13) tick(1);
    chk("t2_run",       maxrun,   10);
    chk("t2_eop_pop",   eop_pops, 1);
    chk("t2_pops",      npops,    2);
    chk("t2_sb_empty",  sb.size(), 0);

    // ---------------- T3: 3-cycle stall at beat 3
    push_word(40'h12_3456_789A);
    tick(1);   // pop
    tick(1);   // beat 12
    tick(1);   // beat 34
    npops = 0;
    repeat (3) begin
      tick(0);
      chk("t3_stall_valid", bus.ser_valid, 1);
      chk("t3_stall_data",  bus.ser_data,  8'h56);
      chk("t3_stall_sop",   bus.ser_sop,   0);
      chk("t3_stall_eop",   bus.ser_eop,   0);
      chk("t3_stall_link",  bus.link_id,   0);
      chk("t3_stall_pop",   bus.buf_pop,   0);
    end
    repeat (4) tick(1);
    chk("t3_pops",     npops,    0);
    chk("t3_sb_empty", sb.size(), 0);

    // ---------------- T4: reset mid-word
    push_word(40'hC0_1122_3344);
    tick(1);   // pop
    tick(1);   // beat 1
    tick(1);   // beat 2 (accepted on next edge)
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", bus.ser_valid, 0);
    chk("t4_rst_data",  bus.ser_data,  0);
    chk("t4_rst_sop",   bus.ser_sop,   0);
    chk("t4_rst_eop",   bus.ser_eop,   0);
    chk("t4_rst_link",  bus.link_id,   0);
    sb.delete();   // remaining beats of the aborted word are lost
    npops = 0;
    repeat (2) tick(1);
    rst = 1'b1;
    repeat (3) begin
      tick(1);
      chk("t4_post_valid", bus.ser_valid, 0);
      chk("t4_post_data",  bus.ser_data,  0);
      chk("t4_post_link",  bus.link_id,   0);
      chk("t4_post_pop",   bus.buf_pop,   0);
    end
    chk("t4_pops", npops, 0);

    // ---------------- T5: empty buffer, ready toggling
    for (int i = 0; i < 8; i++) begin
      tick(i[0]);
      chk("t5_valid", bus.ser_valid, 0);
      chk("t5_pop",   bus.buf_pop,   0);
    end

`ifdef BUFFER_SERIALIZER_PARITY_EN
    // ---------------- T6: parity per beat
    par_hist = '0;
    push_word(40'h01_0300_0700);
    repeat (7) tick(1);
    chk("t6_par_seq",  par_hist[4:0], 5'b10010);
    chk("t6_sb_empty", sb.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/buffer_serializer.md
Name: buffer_serializer

Overview:
- Downstream stage of the link buffer. Drains one DATA_WIDTH word at a time from the buffer's memory head.
- Transmits each word as DATA_WIDTH/LANE_WIDTH narrow beats on an output lane with valid/ready backpressure.
- Extracts the 2-bit link number from the word header and marks start and end of word.
- Feeds the physical link driver and sustains back-to-back words with no idle cycle.

Parameters:
- DATA_WIDTH, 40, buffer word width including header bits. Must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 8, output beat width.
- LINK_BITS, 2, header link-number field width, taken from bits [DATA_WIDTH-1 -: LINK_BITS].

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- buf_data  input  DATA_WIDTH  buffer head word, valid whenever buf_empty=0.
- buf_empty  input  1  buffer empty flag.
- buf_pop  output  1  to buffer next_ready. A 1-cycle pop of the head word.
- ser_data  output  LANE_WIDTH  current beat, MSB-first slice of the word.
- ser_valid  output  1  beat valid.
- ser_ready  input  1  downstream accepts beat.
- ser_sop  output  1  first beat of a word.
- ser_eop  output  1  last beat of a word.
- link_id  output  LINK_BITS  header link number of the word in flight. Stable for all of its beats.

Behaviour:
- BEATS = DATA_WIDTH/LANE_WIDTH. The beat counter is $clog2(BEATS) bits, minimum 1.
- A beat transfers on a rising edge where ser_valid=1 and ser_ready=1.
- FSM states:
  - IDLE: ser_valid=0.
  - SEND: ser_valid=1.
- buf_pop (combinational):
  - buf_pop = !buf_empty && (state==IDLE || (state==SEND && last beat transferring this cycle)).
  - buf_pop is never 1 while rst=0.
- On an edge with buf_pop=1:
  - buf_data is captured into the shift register.
  - link_id is loaded from the header.
  - The beat counter is set to 0.
  - The FSM enters SEND.
- IDLE->SEND latency is 1 cycle: buf_empty falls at cycle N, buf_pop is high in cycle N, first beat is valid in cycle N+1.
- ser_data = shift_reg[DATA_WIDTH-1 -: LANE_WIDTH].
  - On each non-last transfer, shift left by LANE_WIDTH and increment the counter.
- ser_sop = ser_valid && count==0. ser_eop = ser_valid && count==BEATS-1.
- On transfer of the last beat:
  - If buf_empty=1: go to IDLE.
  - Otherwise: reload the next word in the same edge, SEND continues, no bubble.
- Backpressure:
  - While ser_valid=1 and ser_ready=0, ser_data, ser_sop, ser_eop and link_id hold their values.
  - buf_pop stays 0 during a stall.
- Flag changes on buf_empty:
  - A rise during SEND has no effect until the last beat.
  - A fall at the last-beat edge takes effect combinationally.
- BEATS==1: every transfer is both sop and eop, and back-to-back pops are allowed every cycle.
- Reset:
  - Reset values: state=IDLE, shift register=0, counter=0, link_id=0, ser_valid=0, ser_sop=0, ser_eop=0, ser_data=0.
  - Reset asserted mid-word aborts the word. Its remaining beats are lost, because the word was already popped.
  - After reset release, the first pop needs buf_empty=0.

Optional Feature:
- Macro: BUFFER_SERIALIZER_PARITY_EN.
- When defined:
  - Adds output port ser_par (1 bit) = ^ser_data, giving even parity per beat.
  - ser_par holds with ser_data during a stall.
  - Reset value of ser_par is 0.
- When undefined: the port and its logic are absent, with no other behavioural change.

Test Plan:
- Defaults, reset release, buf_data=40'hA1_2233_4455, buf_empty 1->0 at cycle 3, ser_ready=1 -> buf_pop high for cycle 3 only. Beats A1,22,33,44,55 in cycles 4-8. sop in cycle 4, eop in cycle 8. link_id=2'b10. IDLE from cycle 9.
- Two words queued (40'h00_0000_0001 then 40'hFF_FFFF_FFFE), ser_ready=1 -> 10 consecutive valid beats. Second buf_pop coincides with the eop beat of word 1. No idle cycle. link_id changes 00->11 at beat 6.
- ser_ready=0 for 3 cycles at beat 3 of 40'h12_3456_789A -> ser_data holds 8'h56 and no pop occurs. Output resumes 56,78,9A after ser_ready returns to 1.
- rst asserted after beat 2 of a word, released 2 cycles later, buf_empty=1 -> all outputs 0 while reset is held and after release. No pop. Stays IDLE.
- buf_empty=1 throughout with ser_ready toggling -> buf_pop=0 and ser_valid=0 for all cycles.
- With BUFFER_SERIALIZER_PARITY_EN defined, word 40'h01_0300_0700 -> ser_par sequence 1,0,0,1,0.
